// File: rtl/tp_merge_pkg.sv
// rtl/tp_merge_pkg.sv - shared width, flag position and FSM states for the event merger
package tp_merge_pkg;

  localparam int DEFAULT_DATA_WIDTH = 65;

  // The metadata flag is always the top bit of a word.
  function automatic int flag_bit(input int width);
    return width - 1;
  endfunction

  localparam int FLAG_BIT = flag_bit(DEFAULT_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester at or above the pointer
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/event_merger.sv
// rtl/event_merger.sv - merges whole header/body/footer events from N FWFT FIFOs into one stream
module event_merger
  import tp_merge_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_INPUTS   = 2
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [N_INPUTS-1:0]                  in_empty,
  output logic [N_INPUTS-1:0]                  in_read_enable,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_write_enable,
  input  logic                                 out_almost_full,
  output logic [15:0]                          event_count,
  output logic                                 protocol_error
);

  localparam int IW   = $clog2(N_INPUTS);
  localparam int FLAG = flag_bit(DATA_WIDTH);

  logic [1:0]          rst_sync;
  logic                rst_n_int;
  state_t              state, state_next;
  logic [IW-1:0]       rr, sel, grant_idx;
  logic [N_INPUTS-1:0] grant;
  logic                first_word, head_flag;
  logic                pop, discard, footer;

  // Assert immediately, release two clocks after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  rr_arbiter #(.N(N_INPUTS), .IW(IW)) u_arb (
    .req   (~in_empty),
    .ptr   (rr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign head_flag = in_data[sel][FLAG];

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next     = state;
    in_read_enable = '0;
    pop            = 1'b0;
    discard        = 1'b0;
    footer         = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) state_next = GRANT;
      end
      GRANT: begin
        // A headless word can never start an event: drop it and rescan.
        if (!head_flag) begin
          discard    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (!in_empty[sel] && !out_almost_full) begin
          pop = 1'b1;
          if (head_flag && !first_word) begin
            footer     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop || discard) in_read_enable[sel] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rr               <= '0;
      sel              <= '0;
      first_word       <= 1'b0;
      out_write_enable <= 1'b0;
      out_data         <= '0;
      event_count      <= '0;
      protocol_error   <= 1'b0;
    end else begin
      out_write_enable <= pop;
      if (pop) out_data <= in_data[sel];
      if (state == IDLE && |grant) sel <= grant_idx;
      if (state == GRANT && head_flag) first_word <= 1'b1;
      if (pop) first_word <= 1'b0;
      if (discard) protocol_error <= 1'b1;
      if (footer) begin
        rr          <= (sel == IW'(N_INPUTS - 1)) ? '0 : sel + IW'(1);
        event_count <= event_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_event_merger.sv
// tb/tb_event_merger.sv - directed scoreboard bench for event_merger
module tb_event_merger;
  import tp_merge_pkg::*;

  localparam int DW = 65;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic [1:0][DW-1:0] in_data = '0;
  logic [1:0]         in_empty = 2'b11;
  logic [1:0]         in_read_enable;
  logic [DW-1:0]      out_data;
  logic               out_write_enable;
  logic               out_almost_full = 1'b0;
  logic [15:0]        event_count;
  logic               protocol_error;

  int tests = 0;
  int fails = 0;
  int n_written = 0;
  logic [1:0] pend_pop = 2'b00;
  logic [DW-1:0] fifo0 [$];
  logic [DW-1:0] fifo1 [$];
  logic [DW-1:0] exp_q [$];

  event_merger #(.DATA_WIDTH(DW), .N_INPUTS(2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_data          (in_data),
    .in_empty         (in_empty),
    .in_read_enable   (in_read_enable),
    .out_data         (out_data),
    .out_write_enable (out_write_enable),
    .out_almost_full  (out_almost_full),
    .event_count      (event_count),
    .protocol_error   (protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: sample pops and writes mid-cycle, compare writes against the scoreboard.
  always @(negedge clock) begin
    pend_pop = in_read_enable;
    if (out_write_enable === 1'b1) begin
      n_written++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL sb_extra_write: observed %h expected no write", out_data);
      end
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("sb_data", out_data, e);
      end
    end
  end

  // FWFT FIFO models: pop what the DUT popped at this edge, then present the new heads.
  always @(posedge clock) begin
    #1;
    if (pend_pop[0] && fifo0.size() > 0) void'(fifo0.pop_front());
    if (pend_pop[1] && fifo1.size() > 0) void'(fifo1.pop_front());
    in_empty[0] = (fifo0.size() == 0);
    in_empty[1] = (fifo1.size() == 0);
    in_data[0]  = (fifo0.size() == 0) ? '0 : fifo0[0];
    in_data[1]  = (fifo1.size() == 0) ? '0 : fifo1[0];
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [DW-1:0] mk(input logic flag, input int tag, input int low);
    return {flag, 48'(tag), 16'(low)};
  endfunction

  task automatic push(input int port, input logic [DW-1:0] w, input bit expect_out);
    if (port == 0) fifo0.push_back(w);
    else           fifo1.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic load_event(input int port, input int tag, input int nbody);
    push(port, mk(1'b1, tag, 16'h00AA), 1'b1);
    for (int k = 0; k < nbody; k++) push(port, mk(1'b0, tag, k), 1'b1);
    push(port, mk(1'b1, tag, 16'h00FF), 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 500; c++) begin
      if (exp_q.size() == 0 && fifo0.size() == 0 && fifo1.size() == 0) break;
      step();
    end
    check(tag, 65'(exp_q.size()), 65'd0);
    step();
    step();
  endtask

  task automatic wait_written(input string tag, input int target);
    for (int c = 0; c < 500; c++) begin
      if (n_written >= target) break;
      step();
    end
    check(tag, 65'(n_written >= target), 65'd1);
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_we", 65'(out_write_enable), 65'd0);
    check("rst_data", out_data, 65'd0);
    check("rst_rre", 65'(in_read_enable), 65'd0);
    check("rst_count", 65'(event_count), 65'd0);
    check("rst_err", 65'(protocol_error), 65'd0);
    step();
    step();
    reset_n = 1'b1;

    // Two queued events: input 0 first, then input 1, never interleaved
    load_event(0, 32'h10, 2);
    load_event(1, 32'h11, 2);
    wait_drain("two_ev_drain");
    check("two_ev_count", 65'(event_count), 65'd2);
    check("two_ev_rr", 65'(dut.rr), 65'd0);

    // Idle reset pulse clears the counter
    reset_n = 1'b0;
    #1;
    check("pulse_count", 65'(event_count), 65'd0);
    step();
    reset_n = 1'b1;

    // Single event on input 0, input 1 empty
    load_event(0, 32'h20, 3);
    wait_drain("single_drain");
    check("single_count", 65'(event_count), 65'd1);
    check("single_rr", 65'(dut.rr), 65'd1);

    // Backpressure held 10 cycles mid-body
    load_event(0, 32'h30, 6);
    wait_written("stall_start", n_written + 3);
    out_almost_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_rre", 65'(in_read_enable), 65'd0);
      check("stall_we", 65'(out_write_enable), 65'd0);
    end
    out_almost_full = 1'b0;
    wait_drain("stall_drain");
    check("stall_count", 65'(event_count), 65'd2);

    // Input 0 runs dry mid-event; input 1 must wait
    push(0, mk(1'b1, 32'h40, 16'h00AA), 1'b1);
    push(0, mk(1'b0, 32'h40, 0), 1'b1);
    push(0, mk(1'b0, 32'h40, 1), 1'b1);
    exp_q.push_back(mk(1'b0, 32'h40, 2));
    exp_q.push_back(mk(1'b1, 32'h40, 16'h00FF));
    wait_written("dry_start", n_written + 3);
    load_event(1, 32'h41, 1);
    for (int k = 0; k < 20; k++) begin
      step();
      check("dry_rre", 65'(in_read_enable), 65'd0);
      check("dry_state", 65'(dut.state), 65'(XFER));
    end
    push(0, mk(1'b0, 32'h40, 2), 1'b0);
    push(0, mk(1'b1, 32'h40, 16'h00FF), 1'b0);
    wait_drain("dry_drain");
    check("dry_count", 65'(event_count), 65'd4);

    // Headless word is dropped and flagged; the following event still passes
    push(0, mk(1'b0, 32'h50, 16'h0BAD), 1'b0);
    load_event(0, 32'h51, 1);
    wait_drain("err_drain");
    check("err_flag", 65'(protocol_error), 65'd1);
    check("err_count", 65'(event_count), 65'd5);
    load_event(1, 32'h52, 0);
    wait_drain("err_sticky_drain");
    check("err_sticky", 65'(protocol_error), 65'd1);
    check("err_sticky_count", 65'(event_count), 65'd6);

    // Reset mid-event abandons it; afterwards input 0 is served first
    load_event(0, 32'h60, 5);
    wait_written("mid_rst_start", n_written + 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", 65'(out_write_enable), 65'd0);
    check("mid_rst_data", out_data, 65'd0);
    check("mid_rst_rre", 65'(in_read_enable), 65'd0);
    check("mid_rst_count", 65'(event_count), 65'd0);
    check("mid_rst_err", 65'(protocol_error), 65'd0);
    fifo0.delete();
    fifo1.delete();
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    load_event(0, 32'h70, 2);
    load_event(1, 32'h71, 2);
    wait_drain("post_rst_drain");
    check("post_rst_count", 65'(event_count), 65'd2);
    check("post_rst_err", 65'(protocol_error), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_merger.md
EVENT_MERGER -- requirements
Module: event_merger

Interface
REQ-001 Parameter DATA_WIDTH, 65, word width; bit DATA_WIDTH-1 is the metadata flag, bits DATA_WIDTH-2:0 are payload.
REQ-002 Parameter N_INPUTS, 2, number of upstream FIFO read ports; legal range 2..8.
REQ-003 clock  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  [N_INPUTS][DATA_WIDTH]  head word of each upstream first-word-fall-through FIFO, valid when in_empty=0.
REQ-006 in_empty  in  [N_INPUTS]  upstream FIFO empty.
REQ-007 in_read_enable  out  [N_INPUTS]  pop strobe to each upstream FIFO, one-hot or zero.
REQ-008 out_data  out  DATA_WIDTH  word to downstream FIFO write port.
REQ-009 out_write_enable  out  1  downstream write strobe.
REQ-010 out_almost_full  in  1  downstream backpressure.
REQ-011 event_count  out  16  number of complete events written, wraps at 65535->0.
REQ-012 protocol_error  out  1  sticky error flag.

Function
REQ-013 Event = header word (flag=1), zero or more body words (flag=0), footer word (flag=1); events SHALL be forwarded whole, never interleaved across inputs.
REQ-014 FSM states SHALL be IDLE, GRANT, XFER.
REQ-015 IDLE: scan inputs from round-robin pointer rr upward (mod N_INPUTS); first input with in_empty=0 SHALL be registered as sel; move to GRANT; no pop in IDLE.
REQ-016 GRANT: if in_data[sel] flag=0, pop and discard it, set protocol_error, return to IDLE; else move to XFER with first_word=1.
REQ-017 XFER: in_read_enable[sel] = !in_empty[sel] && !out_almost_full, combinational, same cycle.
REQ-018 Each popped word SHALL appear on out_data with out_write_enable=1 exactly one cycle after the pop (registered output, latency 1).
REQ-019 Popped word with flag=1 and first_word=0 is the footer: after it, FSM SHALL go to IDLE, rr SHALL become (sel+1) mod N_INPUTS, event_count SHALL increment.
REQ-020 first_word SHALL clear on the first pop in XFER.
REQ-021 Upstream empty mid-event: stay in XFER, no pops, no timeout.
REQ-022 out_almost_full mid-event: no pops while asserted; resume the cycle it deasserts; no word lost or duplicated.
REQ-023 Empty and almost_full simultaneously: no pop; either clearing alone does not pop.
REQ-024 No inputs non-empty in IDLE: stay in IDLE, all in_read_enable=0.
REQ-025 Worst case: merger sustains one word per cycle in XFER; overhead of 2 idle cycles per event (IDLE, GRANT).

Reset
REQ-026 On reset_n=0: state=IDLE, rr=0, sel=0, first_word=0, out_write_enable=0, out_data=0, in_read_enable=0, event_count=0, protocol_error=0, all asynchronously.
REQ-027 Reset mid-event SHALL abandon the event; any partial event already written downstream is not completed.
REQ-028 Release of reset_n SHALL be synchronised; first scan in the second cycle after release.

Structure
REQ-029 Package tp_merge_pkg SHALL hold DATA_WIDTH default, FLAG_BIT index, and the FSM state enum.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-031 Input 0 holds header 0x1_..AA, 3 body, footer; input 1 empty -> 5 words out in order, event_count=1, rr=1.
REQ-032 Both inputs hold one 4-word event -> input 0 event fully out, then input 1 event, no interleaving, event_count=2.
REQ-033 out_almost_full held high 10 cycles mid-body -> no pops, no writes during hold; output sequence identical to unstalled run.
REQ-034 Input 0 empties after 2 body words for 20 cycles -> merger waits in XFER, input 1 not served; resumes and completes.
REQ-035 Head word flag=0 in GRANT -> word discarded, protocol_error=1 and stays 1, following valid event forwarded.
REQ-036 reset_n pulsed low mid-event -> all outputs zero same cycle; after release next event forwarded from input 0.
